// File: rtl/mlp_pkg.sv
// Shared types, default fixed-point format and rescale/saturate helper for the MLP layer blocks.
package mlp_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W_DEF = 8;

    // Working width for sat_shift; wide enough for any accumulator used by the layer blocks.
    localparam int SAT_W = 128;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ACC,
        S_FINISH,
        S_DONE
    } neuron_state_t;

    // Arithmetic right shift by frac_w (floor), then clamp to a signed data_w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_shift(
        input logic signed [SAT_W-1:0] t,
        input int                      frac_w,
        input int                      data_w
    );
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        r  = t >>> frac_w;
        hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (data_w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_postproc.sv
// Combinational neuron epilogue: bias align and add, rescale, saturate, optional ReLU.
module neuron_postproc
    import mlp_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int FRAC_W  = FRAC_W_DEF,
    parameter int ACC_W   = 42,
    parameter int RELU_EN = 1
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] bias,
    output logic [DATA_W-1:0] result
);

    logic signed [SAT_W-1:0] acc_ext;
    logic signed [SAT_W-1:0] bias_ext;
    logic signed [SAT_W-1:0] t_full;
    logic signed [SAT_W-1:0] sat_full;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        acc_ext  = {{(SAT_W - ACC_W){acc[ACC_W-1]}}, acc};
        bias_ext = {{(SAT_W - DATA_W){bias[DATA_W-1]}}, bias};
        t_full   = acc_ext + (bias_ext <<< FRAC_W);
        sat_full = sat_shift(t_full, FRAC_W, DATA_W);
        result   = sat_full[DATA_W-1:0];
        if (RELU_EN != 0 && sat_full < 0) begin
            result = '0;
        end
    end

endmodule

// File: rtl/neuron_mac_seq.sv
// Time-multiplexed fully-connected neuron: streams inputs, fetches weights from a
// 1-cycle-latency RAM, accumulates, then rescales/saturates into a registered result.
module neuron_mac_seq
    import mlp_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int FRAC_W   = FRAC_W_DEF,
    parameter int N_INPUTS = 784,
    parameter int NEURON_W = 8,
    parameter int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1,
    parameter int ACC_W    = 42,
    parameter int RELU_EN  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [NEURON_W-1:0]       neuron_idx,
    input  logic [DATA_W-1:0]         bias,
    output logic                      busy,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [NEURON_W+IDX_W-1:0] w_addr,
    input  logic [DATA_W-1:0]         w_data,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

    neuron_state_t       state;
    logic [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]    idx;
    logic [NEURON_W-1:0] neuron_q;
    logic [DATA_W-1:0]   bias_q;
    logic [DATA_W-1:0]   post_result;

    logic                       hs;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           prod_ext;

    assign hs       = in_valid & in_ready;
    assign prod     = $signed(in_data) * $signed(w_data);
    assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Presenting idx+hs in ACC means w_data always matches idx on the following cycle.
    always_comb begin
        w_addr = '0;
        if (state == S_FETCH) begin
            w_addr = {neuron_q, {IDX_W{1'b0}}};
        end else if (state == S_ACC) begin
            w_addr = {neuron_q, idx + IDX_W'(hs)};
        end
    end

    neuron_postproc #(
        .DATA_W  (DATA_W),
        .FRAC_W  (FRAC_W),
        .ACC_W   (ACC_W),
        .RELU_EN (RELU_EN)
    ) u_postproc (
        .acc    (acc),
        .bias   (bias_q),
        .result (post_result)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= '0;
            idx       <= '0;
            neuron_q  <= '0;
            bias_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        neuron_q <= neuron_idx;
                        bias_q   <= bias;
                        acc      <= '0;
                        idx      <= '0;
                        busy     <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    in_ready <= 1'b1;
                    state    <= S_ACC;
                end
                S_ACC: begin
                    if (hs) begin
                        acc <= acc + prod_ext;
                        if (idx == LAST_IDX) begin
                            in_ready <= 1'b0;
                            state    <= S_FINISH;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    out_data  <= post_result;
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: a ReLU and a linear instance share stimulus and are checked against a dot-product model.
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  neuron_idx;
    logic [15:0] bias;
    logic [15:0] in_data;
    logic        in_valid;
    logic        out_ready;

    logic        busy_r, in_ready_r, out_valid_r;
    logic [5:0]  w_addr_r;
    logic [15:0] w_data_r, out_data_r;
    logic        busy_l, in_ready_l, out_valid_l;
    logic [5:0]  w_addr_l;
    logic [15:0] w_data_l, out_data_l;

    logic [15:0] wmem [64];

    typedef struct {
        logic [15:0] r;
        logic [15:0] l;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    neuron_mac_seq #(.N_INPUTS(4), .NEURON_W(4), .IDX_W(2), .RELU_EN(1)) dut_r (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_idx(neuron_idx), .bias(bias),
        .busy(busy_r), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_r),
        .w_addr(w_addr_r), .w_data(w_data_r), .out_data(out_data_r),
        .out_valid(out_valid_r), .out_ready(out_ready)
    );

    neuron_mac_seq #(.N_INPUTS(4), .NEURON_W(4), .IDX_W(2), .RELU_EN(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .start(start), .neuron_idx(neuron_idx), .bias(bias),
        .busy(busy_l), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_l),
        .w_addr(w_addr_l), .w_data(w_data_l), .out_data(out_data_l),
        .out_valid(out_valid_l), .out_ready(out_ready)
    );

    // Synchronous weight RAM, one read port per instance.
    always @(posedge clk) begin
        w_data_r <= wmem[w_addr_r];
        w_data_l <= wmem[w_addr_l];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Dot product in real units (Q16.16 integer), plus bias, floor to Q8.8, clamp, optional ReLU.
    function automatic logic [15:0] model(input logic [15:0] ins[4], input logic [15:0] ws[4],
                                          input logic [15:0] b, input bit relu);
        longint s;
        s = longint'($signed(b)) * 256;
        for (int i = 0; i < 4; i++) begin
            s += longint'($signed(ins[i])) * longint'($signed(ws[i]));
        end
        s = s >>> 8;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    // Compare process: whenever a result is presented it must match the model, every cycle.
    always @(negedge clk) begin
        if (rst_n && (out_valid_r || out_valid_l)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", {30'd0, out_valid_r, out_valid_l}, 32'd0);
            end else begin
                check("out_valid_relu", out_valid_r, 1'b1);
                check("out_valid_lin", out_valid_l, 1'b1);
                check("out_data_relu", out_data_r, exp_q[0].r);
                check("out_data_lin", out_data_l, exp_q[0].l);
            end
        end
    end

    // mode: 0 no stalls, 1 fixed pattern 1,0,0,1,1,0,1, 2 random valid.
    task automatic run_job(input logic [3:0] nidx, input logic [15:0] b,
                           input logic [15:0] ins[4], input logic [15:0] ws[4],
                           input int mode, input int hold, input bit start_in_done,
                           output int lat);
        int k, p, stalls, edges, guard;
        logic [5:0] last_addr;
        logic rdy, v;
        exp_t e;
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 4; i++) wmem[{nidx, 2'(i)}] = ws[i];
        e.r = model(ins, ws, b, 1'b1);
        e.l = model(ins, ws, b, 1'b0);
        exp_q.push_back(e);

        @(negedge clk);
        start = 1'b1; neuron_idx = nidx; bias = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; neuron_idx = 4'd0; bias = 16'd0;
        k = 0; p = 0; stalls = 0; edges = 0; guard = 0; last_addr = 6'd0;
        while (k < 4 && guard < 100) begin
            rdy = in_ready_r;
            v = 1'b0;
            if (rdy) begin
                case (mode)
                    0: v = 1'b1;
                    1: v = (p < 7) ? (pat[p] == 1) : 1'b1;
                    default: v = ($urandom_range(0, 1) == 1);
                endcase
                p++;
                if (!v) stalls++;
            end
            in_valid = v;
            in_data = ins[k];
            if (rdy && v) check("w_addr_order", {26'd0, last_addr}, {26'd0, nidx, 2'(k)});
            #1;
            last_addr = w_addr_r;
            @(posedge clk);
            edges++;
            if (rdy && v) k++;
            guard++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("all_handshakes_done", k, 4);

        guard = 0;
        while (!out_valid_r && guard < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            guard++;
        end
        check("out_valid_seen", out_valid_r, 1'b1);
        check("latency", edges, 6 + stalls);
        lat = edges;

        for (int i = 0; i < hold; i++) begin
            if (start_in_done && i == 0) begin
                start = 1'b1; neuron_idx = nidx + 4'd1;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0; neuron_idx = 4'd0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", {busy_r, out_valid_r, busy_l, out_valid_l}, 4'b0000);
        check("out_data_hold_relu", out_data_r, e.r);
        check("out_data_hold_lin", out_data_l, e.l);
        void'(exp_q.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ins[4];
        logic [15:0] ws[4];
        logic [15:0] b;
        int lat, hs;

        for (int i = 0; i < 64; i++) wmem[i] = 16'd0;
        rst_n = 1'b0; start = 1'b0; neuron_idx = 4'd0; bias = 16'd0;
        in_data = 16'd0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {busy_r, busy_l}, 2'b00);
        check("rst_in_ready", {in_ready_r, in_ready_l}, 2'b00);
        check("rst_out_valid", {out_valid_r, out_valid_l}, 2'b00);
        check("rst_out_data", {out_data_r, out_data_l}, 32'd0);
        check("rst_w_addr", {w_addr_r, w_addr_l}, 12'd0);
        rst_n = 1'b1;

        // Hand-computed pins on the model.
        ins = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        ws  = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        check("model_s1", model(ins, ws, 16'h0040, 1'b1), 16'h0240);
        ws  = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        check("model_s2_lin", model(ins, ws, 16'h0000, 1'b0), 16'hFC00);
        check("model_s2_relu", model(ins, ws, 16'h0000, 1'b1), 16'h0000);

        // Scenario 1: nominal, no stalls.
        ws = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run_job(4'd0, 16'h0040, ins, ws, 0, 0, 1'b0, lat);
        check("s1_relu", out_data_r, 16'h0240);
        check("s1_lin", out_data_l, 16'h0240);
        check("s1_latency", lat, 6);

        // Scenario 2: negative result.
        ws = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
        run_job(4'd1, 16'h0000, ins, ws, 0, 0, 1'b0, lat);
        check("s2_relu", out_data_r, 16'h0000);
        check("s2_lin", out_data_l, 16'hFC00);

        // Scenario 3: saturation both ways.
        ins = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        ws  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_job(4'd2, 16'h0000, ins, ws, 0, 0, 1'b0, lat);
        check("s3_pos_lin", out_data_l, 16'h7FFF);
        check("s3_pos_relu", out_data_r, 16'h7FFF);
        ws = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        run_job(4'd2, 16'h0000, ins, ws, 0, 1, 1'b0, lat);
        check("s3_neg_lin", out_data_l, 16'h8000);
        check("s3_neg_relu", out_data_r, 16'h0000);

        // Scenario 4: stall pattern, neuron 3, held DONE with ignored start.
        ins = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
        ws  = '{16'h0080, 16'h0080, 16'h0080, 16'h0080};
        run_job(4'd3, 16'h0040, ins, ws, 1, 3, 1'b1, lat);
        check("s4_latency", lat, 9);
        check("s4_relu", out_data_r, 16'h0240);
        @(negedge clk);
        check("s4_start_ignored", {busy_r, busy_l}, 2'b00);

        // Scenario 5: reset after two handshakes.
        for (int i = 0; i < 4; i++) wmem[{4'd5, 2'(i)}] = 16'h0080;
        @(negedge clk);
        start = 1'b1; neuron_idx = 4'd5; bias = 16'h0040;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        for (int g = 0; g < 20 && hs < 2; g++) begin
            lat = int'(in_ready_r);
            in_valid = 1'b1; in_data = 16'h0100;
            @(posedge clk);
            if (lat == 1) hs++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("s5_two_handshakes", hs, 2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_busy", {busy_r, busy_l}, 2'b00);
        check("s5_rst_in_ready", {in_ready_r, in_ready_l}, 2'b00);
        check("s5_rst_out_valid", {out_valid_r, out_valid_l}, 2'b00);
        check("s5_rst_out_data", {out_data_r, out_data_l}, 32'd0);
        check("s5_rst_w_addr", {w_addr_r, w_addr_l}, 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4'd5, 16'h0040, ins, ws, 0, 0, 1'b0, lat);
        check("s5_relu", out_data_r, 16'h0240);
        check("s5_lin", out_data_l, 16'h0240);

        // Randomized jobs with random stalls and DONE dwell.
        for (int j = 0; j < 30; j++) begin
            for (int i = 0; i < 4; i++) begin
                ins[i] = 16'($urandom);
                ws[i]  = 16'($urandom);
                if (j % 2 == 0) begin
                    ins[i] = {{7{ins[i][8]}}, ins[i][8:0]};
                    ws[i]  = {{7{ws[i][8]}}, ws[i][8:0]};
                end
            end
            b = 16'($urandom);
            run_job(4'($urandom_range(0, 15)), b, ins, ws, 2, $urandom_range(0, 2), 1'b0, lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
